// File: rtl/irrigacao_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irrigacao_pkg
//  Description : Shared definitions for the irrigation command path:
//                state encoding of the pump driver, command width and the
//                default run-time ceiling shared with sistema_irrigacao.
//  Revision    : 1.0 - initial release
// ============================================================================
package irrigacao_pkg;

    // Width of every millisecond quantity on the command path
    localparam int TEMPO_W = 16;

    // Default run-time ceiling (ms), shared with sistema_irrigacao
    localparam int MAX_MS_PADRAO = 25000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COOLDOWN = 2'd2,
        FAULT    = 2'd3
    } estado_t;

    // Clamp a requested run time to the configured ceiling
    function automatic logic [TEMPO_W-1:0] limita_tempo(
        input logic [TEMPO_W-1:0] pedido,
        input logic [TEMPO_W-1:0] teto
    );
        return (pedido > teto) ? teto : pedido;
    endfunction

endpackage
`default_nettype wire

// File: rtl/driver_bomba_temporizado_if.sv
`default_nettype none
// ============================================================================
//  Module      : driver_bomba_temporizado_if
//  Description : Valid/ready command channel carrying the pump run time (ms)
//                from sistema_irrigacao (master) to the pump driver (slave).
//  Signals     : cmd_tempo_bomba_ms [15:0] requested run time in ms
//                cmd_valid                 command valid
//                cmd_ready                 consumer can accept a command
//  Revision    : 1.0 - initial release
// ============================================================================
interface driver_bomba_temporizado_if;
    import irrigacao_pkg::*;

    logic [TEMPO_W-1:0] cmd_tempo_bomba_ms;
    logic               cmd_valid;
    logic               cmd_ready;

    modport master (
        output cmd_tempo_bomba_ms,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_tempo_bomba_ms,
        input  cmd_valid,
        output cmd_ready
    );

endinterface
`default_nettype wire

// File: rtl/gerador_tick_ms.sv
`default_nettype none
// ============================================================================
//  Module      : gerador_tick_ms
//  Description : Millisecond prescaler. Counts 0..TICKS_PER_MS-1 and raises
//                tick during the last count, i.e. once per wrap. clr forces
//                the count back to 0 so a new interval starts cleanly.
//  Ports       : clk   system clock
//                rst_n asynchronous active-low reset
//                clr   synchronous clear of the prescaler
//                tick  one-cycle strobe per millisecond
//  Revision    : 1.0 - initial release
// ============================================================================
module gerador_tick_ms #(
    parameter int TICKS_PER_MS = 50_000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    output logic      tick
);

    localparam int              CNT_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [CNT_W-1:0] C_ULTIMO = CNT_W'(TICKS_PER_MS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == C_ULTIMO);
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/driver_bomba_temporizado.sv
`default_nettype none
// ============================================================================
//  Module      : driver_bomba_temporizado
//  Description : Timed pump driver. Accepts a run time (ms) over a
//                valid/ready channel and holds the pump on for exactly
//                min(cmd, MAX_MS) * TICKS_PER_MS cycles. A low reservoir
//                level forces FAULT, abortar stops the run, and every RUN or
//                FAULT exit is followed by COOLDOWN_MS of pump-off time.
//  Ports       : clk, rst_n            clock / asynchronous active-low reset
//                cmd_if (slave)        command channel (time, valid, ready)
//                alerta_nivel_baixo    low-level interlock input
//                abortar               level-sensitive stop request
//                bomba_on              registered pump drive
//                ocupado               high in RUN, COOLDOWN or FAULT
//                tempo_restante_ms     ms remaining in RUN, 0 elsewhere
//                fim_pulso             1-cycle strobe on normal completion
//                falha                 high while in FAULT
//                total_ciclos          completed-run counter (optional)
//  Options     : DRIVER_BOMBA_ESTATISTICA_EN adds total_ciclos[15:0],
//                counting normal completions, saturating at 16'hFFFF.
//  Notes       : CLK_FREQ_HZ/1000 must be at least 2; MAX_MS and
//                COOLDOWN_MS must fit in 16 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module driver_bomba_temporizado
    import irrigacao_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int MAX_MS      = MAX_MS_PADRAO,
    parameter int COOLDOWN_MS = 2000
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    driver_bomba_temporizado_if.slave   cmd_if,
    input  wire logic                   alerta_nivel_baixo,
    input  wire logic                   abortar,
    output logic                        bomba_on,
    output logic                        ocupado,
    output logic [TEMPO_W-1:0]          tempo_restante_ms,
    output logic                        fim_pulso,
    output logic                        falha
`ifdef DRIVER_BOMBA_ESTATISTICA_EN
    ,
    output logic [15:0]                 total_ciclos
`endif
);

    localparam int                 TICKS_PER_MS = CLK_FREQ_HZ / 1000;
    localparam logic [TEMPO_W-1:0] C_MAX_MS     = TEMPO_W'(MAX_MS);
    localparam logic [TEMPO_W-1:0] C_COOLDOWN   = TEMPO_W'(COOLDOWN_MS);

    estado_t            r_estado;
    logic [TEMPO_W-1:0] r_tempo;
    logic [TEMPO_W-1:0] r_cooldown;
    logic               r_bomba_on;
    logic               r_ocupado;
    logic               r_fim_pulso;
    logic               r_falha;

    logic w_tick;
    logic w_clr;
    logic w_cmd_ready;
    logic w_transfer;
    logic w_fim_run;
    logic w_sai_run;

    assign w_cmd_ready      = (r_estado == IDLE) && !alerta_nivel_baixo;
    assign cmd_if.cmd_ready = w_cmd_ready;
    assign w_transfer       = cmd_if.cmd_valid && w_cmd_ready;

    // Normal completion: the tick that brings the remaining time to zero,
    // only when neither the interlock nor abort takes precedence.
    assign w_fim_run = (r_estado == RUN) && !alerta_nivel_baixo && !abortar
                       && w_tick && (r_tempo == {{(TEMPO_W-1){1'b0}}, 1'b1});

    // Any RUN -> COOLDOWN transition in this cycle
    assign w_sai_run = (r_estado == RUN) && !alerta_nivel_baixo
                       && (abortar || w_fim_run);

    // Holding the prescaler clear in IDLE and FAULT, and on the last RUN
    // cycle, guarantees a fresh count on every entry to RUN and COOLDOWN.
    assign w_clr = (r_estado == IDLE) || (r_estado == FAULT) || w_sai_run;

    gerador_tick_ms #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_gerador_tick_ms (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= IDLE;
            r_tempo     <= '0;
            r_cooldown  <= '0;
            r_bomba_on  <= 1'b0;
            r_ocupado   <= 1'b0;
            r_fim_pulso <= 1'b0;
            r_falha     <= 1'b0;
        end else begin
            r_fim_pulso <= 1'b0;
            case (r_estado)
                IDLE: begin
                    // A zero-length command is consumed without effect
                    if (w_transfer && (cmd_if.cmd_tempo_bomba_ms != '0)) begin
                        r_estado   <= RUN;
                        r_bomba_on <= 1'b1;
                        r_ocupado  <= 1'b1;
                        r_tempo    <= limita_tempo(cmd_if.cmd_tempo_bomba_ms, C_MAX_MS);
                    end
                end

                RUN: begin
                    if (alerta_nivel_baixo) begin
                        r_estado   <= FAULT;
                        r_bomba_on <= 1'b0;
                        r_falha    <= 1'b1;
                        r_tempo    <= '0;
                    end else if (abortar) begin
                        r_estado   <= COOLDOWN;
                        r_bomba_on <= 1'b0;
                        r_tempo    <= '0;
                        r_cooldown <= C_COOLDOWN;
                    end else if (w_tick && (r_tempo != '0)) begin
                        if (w_fim_run) begin
                            r_estado    <= COOLDOWN;
                            r_bomba_on  <= 1'b0;
                            r_fim_pulso <= 1'b1;
                            r_cooldown  <= C_COOLDOWN;
                        end
                        r_tempo <= r_tempo - 1'b1;
                    end
                end

                FAULT: begin
                    if (!alerta_nivel_baixo) begin
                        r_estado   <= COOLDOWN;
                        r_falha    <= 1'b0;
                        r_cooldown <= C_COOLDOWN;
                    end
                end

                COOLDOWN: begin
                    // A zero cooldown still spends one cycle here
                    if (r_cooldown == '0) begin
                        r_estado  <= IDLE;
                        r_ocupado <= 1'b0;
                    end else if (w_tick) begin
                        if (r_cooldown == {{(TEMPO_W-1){1'b0}}, 1'b1}) begin
                            r_estado  <= IDLE;
                            r_ocupado <= 1'b0;
                        end
                        r_cooldown <= r_cooldown - 1'b1;
                    end
                end

                default: begin
                    r_estado   <= IDLE;
                    r_bomba_on <= 1'b0;
                    r_ocupado  <= 1'b0;
                    r_falha    <= 1'b0;
                    r_tempo    <= '0;
                end
            endcase
        end
    end

    assign bomba_on          = r_bomba_on;
    assign ocupado           = r_ocupado;
    assign tempo_restante_ms = r_tempo;
    assign fim_pulso         = r_fim_pulso;
    assign falha             = r_falha;

`ifdef DRIVER_BOMBA_ESTATISTICA_EN
    logic [15:0] r_total_ciclos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total_ciclos <= '0;
        end else if (w_fim_run && (r_total_ciclos != 16'hFFFF)) begin
            r_total_ciclos <= r_total_ciclos + 1'b1;
        end
    end

    assign total_ciclos = r_total_ciclos;
`endif

endmodule
`default_nettype wire

// File: tb/tb_driver_bomba_temporizado.sv
`default_nettype none
// ============================================================================
//  Module      : tb_driver_bomba_temporizado
//  Description : Self-checking bench for driver_bomba_temporizado with
//                CLK_FREQ_HZ=50_000 (50 cycles/ms), COOLDOWN_MS=2. Expected
//                values come from the behavioural timing rules: pump-on
//                cycles, remaining-ms profile, completion outcome and
//                cooldown length per run. Honours DRIVER_BOMBA_ESTATISTICA_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_driver_bomba_temporizado;

    localparam int CLK_FREQ_HZ = 50_000;
    localparam int TICKS       = CLK_FREQ_HZ / 1000;
    localparam int COOLDOWN_MS = 2;
    localparam int MAX_MS      = 25000;

    logic        clk;
    logic        rst_n;
    logic        alerta_nivel_baixo;
    logic        abortar;
    logic        bomba_on;
    logic        ocupado;
    logic [15:0] tempo_restante_ms;
    logic        fim_pulso;
    logic        falha;
`ifdef DRIVER_BOMBA_ESTATISTICA_EN
    logic [15:0] total_ciclos;
`endif

    int checks;
    int errors;
    int exp_total;

    driver_bomba_temporizado_if bus ();

    driver_bomba_temporizado #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .MAX_MS      (MAX_MS),
        .COOLDOWN_MS (COOLDOWN_MS)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_if             (bus.slave),
        .alerta_nivel_baixo (alerta_nivel_baixo),
        .abortar            (abortar),
        .bomba_on           (bomba_on),
        .ocupado            (ocupado),
        .tempo_restante_ms  (tempo_restante_ms),
        .fim_pulso          (fim_pulso),
        .falha              (falha)
`ifdef DRIVER_BOMBA_ESTATISTICA_EN
        ,
        .total_ciclos       (total_ciclos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One complete transaction. ev: 0 = run to completion, 1 = abort after
    // k pump-on cycles, 2 = low-level alert after k pump-on cycles, held for
    // m further cycles before release.
    task automatic executar(input int cmd, input int ev, input int k, input int m);
        int t;
        int h;
        int n;
        int exp_h;
        t = (cmd > MAX_MS) ? MAX_MS : cmd;
        chk("ready_idle", bus.cmd_ready, 1);
        bus.cmd_tempo_bomba_ms = 16'(cmd);
        bus.cmd_valid          = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        if (t == 0) begin
            chk("zero_bomba", bomba_on, 0);
            chk("zero_ocupado", ocupado, 0);
            chk("zero_ready", bus.cmd_ready, 1);
            step();
            chk("zero_bomba2", bomba_on, 0);
            chk("zero_ocupado2", ocupado, 0);
            return;
        end
        chk("run_ocupado", ocupado, 1);
        h = 0;
        while (bomba_on === 1'b1 && h < t * TICKS + 10) begin
            h++;
            chk("tempo_run", tempo_restante_ms, t - (h - 1) / TICKS);
            if (ev == 1 && h == k) abortar = 1'b1;
            if (ev == 2 && h == k) alerta_nivel_baixo = 1'b1;
            step();
        end
        abortar = 1'b0;
        exp_h   = (ev == 0) ? t * TICKS : k;
        chk("ciclos_bomba", h, exp_h);
        chk("fim_pulso", fim_pulso, (ev == 0) ? 1 : 0);
        chk("tempo_zero", tempo_restante_ms, 0);
        chk("ocupado_pos", ocupado, 1);
        if (ev == 0 && exp_total < 65535) exp_total++;
        if (ev == 2) begin
            chk("falha_on", falha, 1);
            for (int i = 0; i < m; i++) begin
                step();
                chk("falha_hold", falha, 1);
            end
            alerta_nivel_baixo = 1'b0;
            step();
            chk("falha_off", falha, 0);
            chk("ocupado_cd", ocupado, 1);
        end else begin
            chk("falha_nao", falha, 0);
        end
        step();
        chk("fim_pulso_1ciclo", fim_pulso, 0);
        n = 1;
        while (bus.cmd_ready !== 1'b1 && n < 1000) begin
            n++;
            step();
        end
        chk("cooldown", n, COOLDOWN_MS * TICKS);
        chk("ocupado_idle", ocupado, 0);
    endtask

    initial begin
        int cmd;
        int ev;
        int k;
        int m;
        checks    = 0;
        errors    = 0;
        exp_total = 0;
        rst_n              = 1'b0;
        alerta_nivel_baixo = 1'b0;
        abortar            = 1'b0;
        bus.cmd_valid          = 1'b0;
        bus.cmd_tempo_bomba_ms = '0;
        repeat (3) step();

        // Reset state
        chk("rst_bomba", bomba_on, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_tempo", tempo_restante_ms, 0);
        chk("rst_fim", fim_pulso, 0);
        chk("rst_falha", falha, 0);
        rst_n = 1'b1;
        step();

        // Normal 3 ms run
        executar(3, 0, 0, 0);
        // Clamp to MAX_MS, then abort
        executar(30000, 1, 60, 0);
        // Interlock during a 5 ms run
        executar(5, 2, 60, 3);
        // Abort coinciding with the final tick: abort wins, no pulse
        executar(1, 1, TICKS, 0);

        // Alert blocks commands; zero command is consumed with no effect
        alerta_nivel_baixo     = 1'b1;
        bus.cmd_tempo_bomba_ms = 16'd3;
        bus.cmd_valid          = 1'b1;
        step();
        chk("alert_ready", bus.cmd_ready, 0);
        step();
        chk("alert_bomba", bomba_on, 0);
        chk("alert_ocupado", ocupado, 0);
        bus.cmd_valid      = 1'b0;
        alerta_nivel_baixo = 1'b0;
        step();
        executar(0, 0, 0, 0);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            cmd = int'($urandom_range(0, 4));
            ev  = int'($urandom_range(0, 2));
            k   = (cmd > 0) ? int'($urandom_range(1, cmd * TICKS)) : 1;
            m   = int'($urandom_range(0, 4));
            executar(cmd, ev, k, m);
        end

        // Asynchronous reset 20 cycles into a 3 ms run
        bus.cmd_tempo_bomba_ms = 16'd3;
        bus.cmd_valid          = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        repeat (19) step();
        chk("pre_rst_bomba", bomba_on, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_bomba", bomba_on, 0);
        chk("arst_ocupado", ocupado, 0);
        chk("arst_tempo", tempo_restante_ms, 0);
        chk("arst_fim", fim_pulso, 0);
        chk("arst_falha", falha, 0);
        exp_total = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("pos_rst_ready", bus.cmd_ready, 1);

        // Two full runs plus one aborted run
        executar(1, 0, 0, 0);
        executar(2, 0, 0, 0);
        executar(2, 1, 30, 0);
`ifdef DRIVER_BOMBA_ESTATISTICA_EN
        chk("total_ciclos", total_ciclos, exp_total);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #20_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
